// File: rtl/signmag_addsub_pipe_pkg.sv
// signmag_addsub_pipe_pkg: shared encodings and the full-adder cell for the sign-magnitude add/sub pipeline
//   OP_ADD / OP_SUB     : op input encoding
//   SIGN_POS / SIGN_NEG : sign bit encoding
//   full_add            : one-bit full adder cell, returns {carry, sum}
package signmag_addsub_pipe_pkg;

   localparam logic OP_ADD   = 1'b0;
   localparam logic OP_SUB   = 1'b1;
   localparam logic SIGN_POS = 1'b0;
   localparam logic SIGN_NEG = 1'b1;

   function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
      return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
   endfunction

endpackage

// File: rtl/signmag_addsub_pipe_twos_negate.sv
// twos_negate: combinational two's-complement negation, invert then +1 through a half-adder ripple
//   a : W-bit operand
//   y : W-bit result, (~a + 1) mod 2^W
module twos_negate #(
   parameter int W = 26
) (
   input  logic [W-1:0] a,
   output logic [W-1:0] y
);

   logic [W-1:0] c;

   assign c[0] = 1'b1;

   genvar i;
   generate
      for (i = 0; i < W; i++) begin : g_bit
         assign y[i] = ~a[i] ^ c[i];
         if (i < W - 1) begin : g_carry
            assign c[i+1] = ~a[i] & c[i];
         end
      end
   endgenerate

endmodule

// File: rtl/signmag_addsub_pipe.sv
// signmag_addsub_pipe: 3-stage pipelined sign-magnitude add/subtract with valid/ready on both sides
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   : operand beat handshake
//   op                    : 0 = A+B, 1 = A-B
//   a_sign, a_mag         : operand A (sign 1 = negative), N-bit magnitude
//   b_sign, b_mag         : operand B
//   out_valid / out_ready : result beat handshake
//   out_sign, out_mag     : result sign (never set on zero) and low N magnitude bits
//   out_carry             : magnitude bit N, only set by an effective add
//   out_zero              : magnitude and carry both zero
module signmag_addsub_pipe
   import signmag_addsub_pipe_pkg::*;
#(
   parameter int N = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op,
   input  logic         a_sign,
   input  logic [N-1:0] a_mag,
   input  logic         b_sign,
   input  logic [N-1:0] b_mag,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_sign,
   output logic [N-1:0] out_mag,
   output logic         out_carry,
   output logic         out_zero
);

   localparam int W = N + 2;

   logic         adv1, adv2, adv3;
   logic         s1_v, s1_sign, s1_sub;
   logic [N-1:0] s1_a;
   logic [W-1:0] s1_b;
   logic         s2_v, s2_sign, s2_sub;
   logic [W-1:0] s2_sum;

   assign adv3     = out_ready || !out_valid;
   assign adv2     = adv3 || !s2_v;
   assign adv1     = adv2 || !s1_v;
   assign in_ready = adv1;

   // S1: fold the operation into an effective add/subtract and pre-negate B
   logic         eff_sub;
   logic [W-1:0] b_ext, b_neg;

   assign eff_sub = a_sign ^ b_sign ^ (op == OP_SUB);
   assign b_ext   = {2'b00, b_mag};

   twos_negate #(.W(W)) u_neg_b (.a(b_ext), .y(b_neg));

   // data registers only load on a real beat so idle X inputs never enter the pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_sign <= 1'b0;
         s1_sub  <= 1'b0;
         s1_a    <= '0;
         s1_b    <= '0;
      end else begin
         if (adv1) s1_v <= in_valid;
         if (adv1 && in_valid) begin
            s1_sign <= a_sign;
            s1_sub  <= eff_sub;
            s1_a    <= a_mag;
            s1_b    <= eff_sub ? b_neg : b_ext;
         end
      end
   end

   // S2: modular N+2-bit ripple add of the two's-complement operands
   logic [W-1:0] a_ext, sum;
   logic [W-1:0] c;

   assign a_ext = {2'b00, s1_a};
   assign c[0]  = 1'b0;

   genvar i;
   generate
      for (i = 0; i < W - 1; i++) begin : g_add
         assign {c[i+1], sum[i]} = full_add(a_ext[i], s1_b[i], c[i]);
      end
   endgenerate

   assign sum[W-1] = a_ext[W-1] ^ s1_b[W-1] ^ c[W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v    <= 1'b0;
         s2_sign <= 1'b0;
         s2_sub  <= 1'b0;
         s2_sum  <= '0;
      end else begin
         if (adv2) s2_v <= s1_v;
         if (adv2 && s1_v) begin
            s2_sign <= s1_sign;
            s2_sub  <= s1_sub;
            s2_sum  <= sum;
         end
      end
   end

   // S3: a negative difference (top bit set) flips the sign and is negated back to a magnitude
   logic [W-1:0] sum_neg;
   logic         neg_res, res_carry, res_zero, res_sign;
   logic [N-1:0] res_mag;
   logic         unused_neg_hi;

   twos_negate #(.W(W)) u_neg_sum (.a(s2_sum), .y(sum_neg));

   assign unused_neg_hi = ^sum_neg[W-1:N];
   assign neg_res       = s2_sub && s2_sum[W-1];
   assign res_mag       = neg_res ? sum_neg[N-1:0] : s2_sum[N-1:0];
   assign res_carry     = !s2_sub && s2_sum[N];
   assign res_zero      = (res_mag == '0) && !res_carry;
   assign res_sign      = res_zero ? SIGN_POS : (s2_sign ^ neg_res);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sign  <= 1'b0;
         out_mag   <= '0;
         out_carry <= 1'b0;
         out_zero  <= 1'b0;
      end else begin
         if (adv3) out_valid <= s2_v;
         if (adv3 && s2_v) begin
            out_sign  <= res_sign;
            out_mag   <= res_mag;
            out_carry <= res_carry;
            out_zero  <= res_zero;
         end
      end
   end

endmodule

// File: tb/tb_signmag_addsub_pipe.sv
// tb_signmag_addsub_pipe: scoreboard bench for the sign-magnitude add/sub pipeline at N=8
module tb_signmag_addsub_pipe;

   localparam int N = 8;

   typedef struct packed {
      logic         sign;
      logic         carry;
      logic [N-1:0] mag;
      logic         zero;
   } res_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         op = 1'b0;
   logic         a_sign = 1'b0;
   logic [N-1:0] a_mag = '0;
   logic         b_sign = 1'b0;
   logic [N-1:0] b_mag = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic         out_sign;
   logic [N-1:0] out_mag;
   logic         out_carry;
   logic         out_zero;

   res_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ready_mode = 0;

   signmag_addsub_pipe #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a_sign(a_sign), .a_mag(a_mag), .b_sign(b_sign), .b_mag(b_mag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_mag(out_mag), .out_carry(out_carry), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic o, input logic as, input int a,
                                  input logic bs, input int b);
      int sa, sb, r, m;
      res_t e;
      sa = as ? -a : a;
      sb = bs ? -b : b;
      r  = o ? sa - sb : sa + sb;
      m  = (r < 0) ? -r : r;
      e.sign  = (r < 0);
      e.mag   = m[N-1:0];
      e.carry = m[N];
      e.zero  = (m == 0);
      return e;
   endfunction

   // ready policy chosen per test; results compared at the negedge before they transfer
   always @(negedge clk) begin
      res_t got, exp;
      out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rst_n && out_valid && out_ready) begin
         got = {out_sign, out_carry, out_mag, out_zero};
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat got=%h expected=none", got);
         end else begin
            exp = q.pop_front();
            if (got !== exp) begin
               n_bad++;
               $display("FAIL result got s=%b c=%b m=%0d z=%b expected s=%b c=%b m=%0d z=%b",
                        got.sign, got.carry, got.mag, got.zero, exp.sign, exp.carry, exp.mag, exp.zero);
            end
         end
      end
   end

   task automatic send(input logic o, input logic as, input int a, input logic bs, input int b);
      @(negedge clk); #1;
      op = o; a_sign = as; a_mag = N'(a); b_sign = bs; b_mag = N'(b);
      in_valid = 1'b1;
      for (int t = 0; t < 200 && !in_ready; t++) begin
         @(negedge clk); #1;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout in_ready=%b expected=1", in_ready);
      end else begin
         q.push_back(model(o, as, a, bs, b));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 1'bx; a_sign = 1'bx; a_mag = 'x; b_sign = 1'bx; b_mag = 'x;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain_timeout pending=%0d expected=0", q.size());
      end
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); #1;
      n_cmp++;
      if ({out_valid, out_sign, out_carry, out_mag, out_zero} !== '0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_state out=%b_%b_%b_%h_%b in_ready=%b expected all 0, in_ready=1",
                  out_valid, out_sign, out_carry, out_mag, out_zero, in_ready);
      end
   endtask

   task automatic test_sub_basic();
      send(1, 0, 5, 0, 3);
      send(1, 0, 3, 0, 5);
      send(0, 1, 3, 0, 5);
      send(1, 1, 3, 0, 5);
      drain();
   endtask

   task automatic test_zero();
      send(1, 0, 200, 0, 200);
      send(0, 1, 7, 0, 7);
      send(0, 1, 0, 1, 0);
      send(1, 1, 0, 0, 0);
      send(1, 0, 9, 0, 0);
      send(0, 0, 9, 1, 0);
      drain();
   endtask

   task automatic test_full_scale();
      send(0, 0, 255, 0, 255);
      send(0, 1, 255, 1, 1);
      send(1, 0, 255, 1, 255);
      send(1, 1, 0, 0, 255);
      drain();
   endtask

   task automatic test_stall();
      logic [N+3:0] held;
      ready_mode = 2;
      send(0, 0, 10, 0, 20);
      send(1, 0, 10, 0, 20);
      send(1, 1, 40, 1, 2);
      @(negedge clk); #1;
      held = {out_valid, out_sign, out_carry, out_mag, out_zero};
      in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL full_stall_in_ready got=%b expected=0", in_ready);
      end
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({out_valid, out_sign, out_carry, out_mag, out_zero} !== held || held[N+3] !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_hold got=%h expected=%h with valid", {out_valid, out_sign, out_carry, out_mag, out_zero}, held);
      end
      in_valid = 1'b0;
      ready_mode = 0;
      send(0, 1, 100, 0, 1);
      drain();
   endtask

   task automatic test_back_to_back();
      ready_mode = 1;
      for (int k = 0; k < 20; k++)
         send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255),
              1'($urandom_range(0, 1)), (k % 5 == 0) ? 255 : $urandom_range(0, 255));
      drain();
      ready_mode = 0;
   endtask

   task automatic test_reset_midflight();
      int cnt;
      logic seen;
      ready_mode = 2;
      send(0, 0, 1, 0, 2);
      send(0, 0, 3, 0, 4);
      send(0, 0, 5, 0, 6);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, out_sign, out_carry, out_mag, out_zero} !== '0) begin
         n_bad++;
         $display("FAIL async_reset out=%b_%b_%b_%h_%b expected all 0",
                  out_valid, out_sign, out_carry, out_mag, out_zero);
      end
      q.delete();
      ready_mode = 0;
      @(negedge clk); @(negedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen |= out_valid;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL stale_beat out_valid=%b expected=0", seen);
      end
      send(1, 0, 50, 1, 25);
      cnt = 1;
      while (!out_valid && cnt < 10) begin
         @(posedge clk); #1;
         cnt++;
      end
      n_cmp++;
      if (cnt != 3) begin
         n_bad++;
         $display("FAIL latency got=%0d edges expected=3", cnt);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_sub_basic();
      test_zero();
      test_full_scale();
      test_stall();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time_limit reached expected completion");
      $fatal(1, "watchdog");
   end

endmodule
